trail_vertex_ctrl: RTL and testbench

// - Owns the line-body vertex store: DEPTH turn points, newest first, in a circular single-port RAM.
// - Captures the head position on each press into a small staging FIFO.
// - Commits staged vertices only at frame start, so the renderer sees a frame-stable vertex set.
// - Arbitrates the RAM between commit writes and renderer reads; the pixel engine iterates segments via rd_req/rd_idx.

---
 rtl/trail_vertex_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_trail_vertex_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_vertex_ctrl.sv
// trail_vertex_ctrl: line-body vertex store with frame-synchronous commit.
// Presses are staged in a small FIFO and written into a circular vertex RAM
// only at frame start, so the renderer always sees a frame-stable set.
// Optional feature: define TRAIL_DEDUP_EN to drop presses that repeat the
// most recently accepted vertex.
module trail_vertex_ctrl #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int CW      = 16,
   parameter int PEND    = 2,
   parameter int START_X = 336,
   parameter int START_Y = 240
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          press,
   input  logic [CW-1:0] head_x,
   input  logic [CW-1:0] head_y,
   input  logic          frame_start,
   input  logic          clear,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_idx,
   output logic          rd_vld,
   output logic          rd_inrange,
   output logic [CW-1:0] rd_x,
   output logic [CW-1:0] rd_y,
   output logic [AW:0]   view_cnt,
   output logic          busy,
   output logic          ovf
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_COMMIT, S_SNAP} state_t;

   localparam int PW = (PEND > 1) ? $clog2(PEND) : 1;
   localparam int NW = $clog2(PEND + 1);
   localparam logic [CW-1:0] SX = CW'(START_X);
   localparam logic [CW-1:0] SY = CW'(START_Y);

   state_t          state;
   logic [2*CW-1:0] mem [DEPTH];
   logic [2*CW-1:0] fifo_mem [PEND];
   logic [PW-1:0]   fifo_rd;
   logic [PW-1:0]   fifo_wr;
   logic [NW-1:0]   fifo_cnt;
   logic [NW-1:0]   commit_n;
   logic [NW-1:0]   commit_left;
   logic [AW-1:0]   clr_idx;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   view_head;

   logic            pop;
   logic            has_space;
   logic            press_live;
   logic            dup;
   logic            push;
   logic            drop;
   logic            mem_we;
   logic [AW-1:0]   mem_wa;
   logic [2*CW-1:0] mem_wd;
   logic [AW-1:0]   rd_addr;
   logic            rd_hit;
   logic [2*CW-1:0] rd_word;
   logic [AW+1:0]   cnt_sum;

`ifdef TRAIL_DEDUP_EN
   logic [2*CW-1:0] last_xy;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(PEND - 1)) ? '0 : p + 1'b1;
   endfunction

   assign busy       = (state != S_IDLE);
   assign pop        = (state == S_COMMIT) && !clear;
   assign has_space  = (fifo_cnt < NW'(PEND)) || pop;
   assign press_live = press && (state != S_CLEAR) && !clear;
`ifdef TRAIL_DEDUP_EN
   assign dup        = ({head_x, head_y} == last_xy);
`else
   assign dup        = 1'b0;
`endif
   assign push       = press_live && !dup && has_space;
   assign drop       = press_live && !dup && !has_space;

   assign rd_addr    = view_head - AW'(1) - rd_idx;
   assign rd_hit     = ({1'b0, rd_idx} < view_cnt);
   assign rd_word    = mem[rd_addr];
   assign cnt_sum    = {1'b0, view_cnt} + (AW+2)'(commit_n);

   // Select the single RAM writer: the CLEAR sweep or the oldest staged vertex during COMMIT.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wr_ptr;
      mem_wd = fifo_mem[fifo_rd];
      if (state == S_CLEAR) begin
         mem_we = 1'b1;
         mem_wa = clr_idx;
         mem_wd = {SX, SY};
      end else if (pop) begin
         mem_we = 1'b1;
      end
   end

   // Vertex RAM and staging storage; contents need no reset since pointers and counts gate them.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      if (push) fifo_mem[fifo_wr] <= {head_x, head_y};
   end

   // Control FSM, staging pointers, view snapshot and registered read response.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_CLEAR;
         clr_idx     <= '0;
         wr_ptr      <= '0;
         view_head   <= '0;
         view_cnt    <= '0;
         ovf         <= 1'b0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
         fifo_cnt    <= '0;
         commit_n    <= '0;
         commit_left <= '0;
         rd_vld      <= 1'b0;
         rd_inrange  <= 1'b0;
         rd_x        <= SX;
         rd_y        <= SY;
`ifdef TRAIL_DEDUP_EN
         last_xy     <= {SX, SY};
`endif
      end else begin
         rd_vld <= 1'b0;
         if ((state == S_IDLE) && rd_req) begin
            rd_vld     <= 1'b1;
            rd_inrange <= rd_hit;
            rd_x       <= rd_hit ? rd_word[2*CW-1:CW] : SX;
            rd_y       <= rd_hit ? rd_word[CW-1:0]    : SY;
         end
         if (push) begin
            fifo_wr <= ptr_inc(fifo_wr);
`ifdef TRAIL_DEDUP_EN
            last_xy <= {head_x, head_y};
`endif
         end
         if (pop) begin
            fifo_rd <= ptr_inc(fifo_rd);
            wr_ptr  <= wr_ptr + AW'(1);
         end
         fifo_cnt <= fifo_cnt + NW'(push) - NW'(pop);
         if (drop) ovf <= 1'b1;

         if (clear || (state == S_CLEAR)) begin
            fifo_rd   <= '0;
            fifo_wr   <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            view_head <= '0;
            view_cnt  <= '0;
            ovf       <= 1'b0;
`ifdef TRAIL_DEDUP_EN
            last_xy   <= {SX, SY};
`endif
         end

         if (clear) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
         end else begin
            case (state)
               S_CLEAR: begin
                  clr_idx <= clr_idx + AW'(1);
                  if (clr_idx == AW'(DEPTH - 1)) state <= S_IDLE;
               end
               S_IDLE: begin
                  if (frame_start && (fifo_cnt != '0)) begin
                     state       <= S_COMMIT;
                     commit_n    <= fifo_cnt;
                     commit_left <= fifo_cnt;
                  end
               end
               S_COMMIT: begin
                  commit_left <= commit_left - NW'(1);
                  if (commit_left == NW'(1)) state <= S_SNAP;
               end
               S_SNAP: begin
                  view_head <= wr_ptr;
                  view_cnt  <= (cnt_sum > (AW+2)'(DEPTH)) ? (AW+1)'(DEPTH) : cnt_sum[AW:0];
                  state     <= S_IDLE;
               end
               default: state <= S_CLEAR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trail_vertex_ctrl.sv
// Self-checking bench for trail_vertex_ctrl: a directed vector table for the
// basic commit/read flow plus hand-written wrap, clear and dedup sequences.
module tb_trail_vertex_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        press = 1'b0;
   logic [15:0] head_x = '0;
   logic [15:0] head_y = '0;
   logic        frame_start = 1'b0;
   logic        clear = 1'b0;
   logic        rd_req = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic        rd_vld;
   logic        rd_inrange;
   logic [15:0] rd_x;
   logic [15:0] rd_y;
   logic [4:0]  view_cnt;
   logic        busy;
   logic        ovf;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic        press;
      logic [15:0] hx;
      logic [15:0] hy;
      logic        fs;
      logic        rd;
      logic [3:0]  idx;
      logic        e_vld;
      logic        e_in;
      logic [15:0] e_x;
      logic [15:0] e_y;
      logic [4:0]  e_vc;
      logic        e_busy;
      logic        e_ovf;
   } vec_t;

   vec_t tbl[25];

   trail_vertex_ctrl dut (
      .clk(clk), .reset_n(reset_n), .press(press), .head_x(head_x), .head_y(head_y),
      .frame_start(frame_start), .clear(clear), .rd_req(rd_req), .rd_idx(rd_idx),
      .rd_vld(rd_vld), .rd_inrange(rd_inrange), .rd_x(rd_x), .rd_y(rd_y),
      .view_cnt(view_cnt), .busy(busy), .ovf(ovf)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends with a visible failure.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input int p, input int hx, input int hy, input int fs,
                               input int rd, input int idx, input int vld, input int inr,
                               input int x, input int y, input int vc, input int bsy,
                               input int ov);
      vec_t v;
      v.press = p[0];   v.hx = hx[15:0]; v.hy = hy[15:0]; v.fs = fs[0];
      v.rd = rd[0];     v.idx = idx[3:0];
      v.e_vld = vld[0]; v.e_in = inr[0]; v.e_x = x[15:0]; v.e_y = y[15:0];
      v.e_vc = vc[4:0]; v.e_busy = bsy[0]; v.e_ovf = ov[0];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      press = v.press; head_x = v.hx; head_y = v.hy;
      frame_start = v.fs; rd_req = v.rd; rd_idx = v.idx;
      tick();
      press = 1'b0; frame_start = 1'b0; rd_req = 1'b0;
   endtask

   task automatic do_press(input int x, input int y);
      press = 1'b1; head_x = x[15:0]; head_y = y[15:0];
      tick();
      press = 1'b0;
   endtask

   task automatic do_read(input int idx);
      rd_req = 1'b1; rd_idx = idx[3:0];
      tick();
      rd_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 64) begin
         tick();
         n++;
      end
      check_output(name, busy, 0);
   endtask

   initial begin
      int n;
      int exp_vc;

      tbl[0]  = mk(0,   0,   0, 0, 1, 0,  1, 0, 336, 240, 0, 0, 0);
      tbl[1]  = mk(1, 400, 240, 0, 0, 0,  0, 0, 336, 240, 0, 0, 0);
      tbl[2]  = mk(0,   0,   0, 1, 0, 0,  0, 0, 336, 240, 0, 1, 0);
      tbl[3]  = mk(0,   0,   0, 0, 1, 0,  0, 0, 336, 240, 0, 1, 0);
      tbl[4]  = mk(0,   0,   0, 0, 0, 0,  0, 0, 336, 240, 1, 0, 0);
      tbl[5]  = mk(0,   0,   0, 0, 1, 0,  1, 1, 400, 240, 1, 0, 0);
      tbl[6]  = mk(1, 400, 300, 0, 0, 0,  0, 0, 400, 240, 1, 0, 0);
      tbl[7]  = mk(0,   0,   0, 0, 1, 0,  1, 1, 400, 240, 1, 0, 0);
      tbl[8]  = mk(0,   0,   0, 1, 0, 0,  0, 0, 400, 240, 1, 1, 0);
      tbl[9]  = mk(0,   0,   0, 0, 0, 0,  0, 0, 400, 240, 1, 1, 0);
      tbl[10] = mk(0,   0,   0, 0, 0, 0,  0, 0, 400, 240, 2, 0, 0);
      tbl[11] = mk(0,   0,   0, 0, 1, 0,  1, 1, 400, 300, 2, 0, 0);
      tbl[12] = mk(0,   0,   0, 0, 1, 1,  1, 1, 400, 240, 2, 0, 0);
      tbl[13] = mk(0,   0,   0, 0, 1, 2,  1, 0, 336, 240, 2, 0, 0);
      tbl[14] = mk(1,   1,  10, 0, 0, 0,  0, 0, 336, 240, 2, 0, 0);
      tbl[15] = mk(1,   2,  20, 0, 0, 0,  0, 0, 336, 240, 2, 0, 0);
      tbl[16] = mk(1,   3,  30, 0, 0, 0,  0, 0, 336, 240, 2, 0, 1);
      tbl[17] = mk(0,   0,   0, 1, 0, 0,  0, 0, 336, 240, 2, 1, 1);
      tbl[18] = mk(0,   0,   0, 0, 0, 0,  0, 0, 336, 240, 2, 1, 1);
      tbl[19] = mk(0,   0,   0, 0, 0, 0,  0, 0, 336, 240, 2, 1, 1);
      tbl[20] = mk(0,   0,   0, 0, 0, 0,  0, 0, 336, 240, 4, 0, 1);
      tbl[21] = mk(0,   0,   0, 0, 1, 0,  1, 1,   2,  20, 4, 0, 1);
      tbl[22] = mk(0,   0,   0, 0, 1, 1,  1, 1,   1,  10, 4, 0, 1);
      tbl[23] = mk(0,   0,   0, 0, 1, 3,  1, 1, 400, 240, 4, 0, 1);
      tbl[24] = mk(0,   0,   0, 1, 1, 4,  1, 0, 336, 240, 4, 0, 1);

      // Reset state.
      repeat (3) tick();
      check_output("rst_rd_vld", rd_vld, 0);
      check_output("rst_rd_inrange", rd_inrange, 0);
      check_output("rst_rd_x", rd_x, 336);
      check_output("rst_rd_y", rd_y, 240);
      check_output("rst_view_cnt", view_cnt, 0);
      check_output("rst_busy", busy, 1);
      check_output("rst_ovf", ovf, 0);

      // CLEAR sweep after reset release lasts one cycle per slot.
      reset_n = 1'b1;
      n = 0;
      while (busy && n < 64) begin
         n++;
         tick();
      end
      check_output("rst_busy_cycles", n, 16);

      // Directed vector table.
      for (int i = 0; i < 25; i++) begin
         apply_stimulus(tbl[i]);
         check_output($sformatf("v%0d_rd_vld", i), rd_vld, tbl[i].e_vld);
         if (tbl[i].e_vld)
            check_output($sformatf("v%0d_rd_inrange", i), rd_inrange, tbl[i].e_in);
         check_output($sformatf("v%0d_rd_x", i), rd_x, tbl[i].e_x);
         check_output($sformatf("v%0d_rd_y", i), rd_y, tbl[i].e_y);
         check_output($sformatf("v%0d_view_cnt", i), view_cnt, tbl[i].e_vc);
         check_output($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         check_output($sformatf("v%0d_ovf", i), ovf, tbl[i].e_ovf);
      end

      // Seventeen one-press frames wrap the store; a read during COMMIT is refused.
      for (int k = 1; k <= 17; k++) begin
         do_press(k, 50);
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         if (k == 1) begin
            do_read(0);
            check_output("commit_rd_vld", rd_vld, 0);
         end
         wait_idle($sformatf("frame%0d_idle", k));
      end
      check_output("wrap_view_cnt", view_cnt, 16);
      check_output("wrap_ovf_sticky", ovf, 1);
      do_read(0);
      check_output("wrap_idx0_vld", rd_vld, 1);
      check_output("wrap_idx0_x", rd_x, 17);
      check_output("wrap_idx0_y", rd_y, 50);
      do_read(15);
      check_output("wrap_idx15_in", rd_inrange, 1);
      check_output("wrap_idx15_x", rd_x, 2);

      // clear mid-COMMIT restarts the CLEAR sweep and discards staged work.
      do_press(5, 5);
      do_press(6, 6);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      check_output("midcommit_busy", busy, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n = 0;
      while (busy && n < 64) begin
         if (n == 3) begin
            press = 1'b1; head_x = 16'd7; head_y = 16'd7;
         end
         n++;
         tick();
         press = 1'b0;
      end
      check_output("clear_busy_cycles", n, 16);
      check_output("clear_view_cnt", view_cnt, 0);
      check_output("clear_ovf", ovf, 0);
      do_read(0);
      check_output("clear_rd_vld", rd_vld, 1);
      check_output("clear_rd_inrange", rd_inrange, 0);
      check_output("clear_rd_x", rd_x, 336);
      check_output("clear_rd_y", rd_y, 240);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_output("clear_staging_empty", busy, 0);

      // Repeated press of the same head position.
      do_press(400, 240);
      do_press(400, 240);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_idle("dedup_idle");
`ifdef TRAIL_DEDUP_EN
      exp_vc = 1;
`else
      exp_vc = 2;
`endif
      check_output("dedup_view_cnt", view_cnt, exp_vc);
      check_output("dedup_ovf", ovf, 0);
      do_read(0);
      check_output("dedup_idx0_x", rd_x, 400);
      check_output("dedup_idx0_y", rd_y, 240);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
